pos_link_rx: RTL and testbench
==============================

Name: pos_link_rx

Overview:
- Receive side of the board-to-board paddle link used in multiplayer mode. The peer board serializes its 10-bit paddle position onto one wire.
- This block oversamples that wire in the clk65MHz domain, checks framing and parity, and holds the last good position.
- That position drives input_pos into draw_rect_ctl and ball_control.
- Also reports link health, so the game can fall back to a centred paddle when the peer is absent.

Parameters:
- CLKS_PER_BIT, 65: clk65MHz cycles per serial bit (1 Mbaud); must be >= 4.
- TIMEOUT_CLKS, 1300000: cycles without a good frame before link_up drops (20 ms).
- RESET_POS, 377: position presented at reset and after link timeout.

Ports:
- clk65MHz  input  1: system pixel clock, all logic on rising edge.
- rst  input  1: synchronous, active-high reset.
- rx_serial  input  1: asynchronous serial line from peer board; idles high.
- pos  output  10: last accepted peer paddle position.
- pos_valid  output  1: one-cycle pulse when pos is updated from a good frame.
- parity_err  output  1: one-cycle pulse on a parity mismatch.
- frame_err  output  1: one-cycle pulse on a bad stop bit.
- link_up  output  1: high while good frames arrive within TIMEOUT_CLKS of each other.

Behaviour:
- Clock and reset: one clock (clk65MHz). Reset is synchronous and active-high (rst).
- Reset values: pos=RESET_POS, pos_valid=0, parity_err=0, frame_err=0, link_up=0, FSM=IDLE, timeout counter=0.
- Synchronizer: rx_serial passes through a 2-FF synchronizer; rx_s is its output. All decisions use rx_s only. The synchronizer FFs reset to 1.
- Frame format, 13 bits: start(0), d[0]..d[9] LSB first, even parity (XOR of d[9:0]), stop(1).
- Timing: let C=CLKS_PER_BIT, H=C/2 (integer division), t0 = first cycle rx_s==0 while in IDLE.
  - Start sample at t0+H.
  - Data bit i sampled at t0+H+(i+1)*C.
  - Parity sampled at t0+H+11C.
  - Stop sampled at t0+H+12C.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: wait for rx_s==0, then load bit counter and go to START.
  - START: at mid-bit, if rx_s==1 (glitch) return to IDLE with no error pulse; else go to DATA.
  - DATA: shift 10 bits LSB first, then go to PARITY.
  - PARITY: latch the parity bit.
  - STOP, at mid-bit, exactly one of three cases:
    - rx_s==0: frame_err pulse, go to BREAK.
    - rx_s==1 and parity mismatch: parity_err pulse, pos unchanged, go to IDLE.
    - rx_s==1 and parity ok: pos<=data, pos_valid pulse, go to IDLE.
  - BREAK: wait until rx_s==1, then go to IDLE. A long low line produces exactly one frame_err.
- Output latency: pos, pos_valid and the error pulses are registered and appear at stop-sample cycle +1. Return to IDLE happens at the stop sample, not at the end of the stop bit, to tolerate peer clock drift.
- Frame error and parity: frame_err takes precedence; parity is not evaluated when the stop bit is bad.
- link_up and timeout counter:
  - A good frame clears the counter and sets link_up=1 in the same cycle as pos_valid.
  - Otherwise the counter increments, saturating at TIMEOUT_CLKS.
  - When the counter reaches TIMEOUT_CLKS while link_up==1: link_up<=0 and pos<=RESET_POS in the same cycle, no pos_valid pulse.
  - Bad frames do not refresh the counter.
- Reset mid-frame: the partial frame is discarded and no pulses are emitted. The next frame is received only after a fresh falling edge seen in IDLE.
- Back-to-back frames, where the next start bit immediately follows the stop bit, are all received with no gap required.

Decomposition:
- Package pong_link_pkg:
  - POS_W=10, FRAME_DATA_BITS=10.
  - Enum typedef link_rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Function even_parity(logic [9:0]).
  - The matching pos_link_tx uses the same package.
- Sub-module: bit_sync2, a generic 2-FF synchronizer with a reset value parameter (here 1).
- The FSM, bit/baud counters and timeout counter stay in pos_link_rx.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_CLKS=2000 unless stated):
1. Reset with line idle high -> pos=377, link_up=0, no pulses for 500 cycles.
2. Send good frame 10'd600 (parity 0) -> pos=600 and a single pos_valid pulse at stop-sample+1; link_up=1; no error pulses.
3. Send 10'd5 with parity forced to 1 -> parity_err pulse once, pos stays 600, link_up unaffected.
4. Send frame with stop bit 0, then hold line low 300 cycles -> exactly one frame_err, no update; next good frame 10'd123 -> pos=123.
5. 3-cycle low glitch on idle line -> no pulses, FSM back in IDLE. Also: three back-to-back frames 1, 2, 1023 -> three pos_valid pulses with pos 1, 2, 1023 in order.
6. After a good frame, idle 2000 cycles -> link_up falls and pos=377 on the same cycle. Also: rst asserted mid-DATA, then a good frame 10'd42 -> pos=42 with no spurious pulses.

Source files
------------

// File: rtl/pong_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pong_link_pkg                                               |
// | Brief  : Shared types and helpers for the board-to-board paddle     |
// |          link (pos_link_rx / pos_link_tx).                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package pong_link_pkg;

  localparam int POS_W           = 10;
  localparam int FRAME_DATA_BITS = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } link_rx_state_t;

  // Even parity bit for a paddle word: the XOR of all data bits.
  function automatic logic even_parity(input logic [9:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pos_link_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pos_link_rx_if                                              |
// | Brief  : Serial line plus decoded position/status bundle for the    |
// |          paddle link receiver.                                       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface pos_link_rx_if;
  import pong_link_pkg::*;

  logic             rx_serial;
  logic [POS_W-1:0] pos;
  logic             pos_valid;
  logic             parity_err;
  logic             frame_err;
  logic             link_up;

  // Peer/consumer side: drives the wire, observes the decoded result.
  modport master (
    output rx_serial,
    input  pos, pos_valid, parity_err, frame_err, link_up
  );

  // Receiver side.
  modport slave (
    input  rx_serial,
    output pos, pos_valid, parity_err, frame_err, link_up
  );

endinterface
`default_nettype wire

// File: rtl/bit_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bit_sync2                                                   |
// | Brief  : Two-flop synchronizer for a single asynchronous bit, with  |
// |          a configurable reset value.                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bit_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pos_link_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pos_link_rx                                                 |
// | Brief  : Oversampling receiver for the peer paddle position. Checks |
// |          start/parity/stop framing, holds the last good position    |
// |          and tracks link health with a frame timeout.               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module pos_link_rx
  import pong_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 65,
  parameter int TIMEOUT_CLKS = 1300000,
  parameter int RESET_POS    = 377
) (
  input  wire logic    clk65MHz,
  input  wire logic    rst,
  pos_link_rx_if.slave link
);

  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int c_TO_W   = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [c_BAUD_W-1:0] c_HALF_M1  = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_BAUD_W-1:0] c_FULL_M1  = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(TIMEOUT_CLKS);
  localparam logic [c_TO_W-1:0]   c_TO_LAST  = c_TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]          c_LAST_BIT = 4'(FRAME_DATA_BITS - 1);
  localparam logic [POS_W-1:0]    c_RESET_POS = POS_W'(RESET_POS);

  logic w_rx_s;

  link_rx_state_t r_state, w_state_nxt;
  logic [c_BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [3:0]          r_bit, w_bit_nxt;
  logic [POS_W-1:0]    r_shift, w_shift_nxt;
  logic                r_par, w_par_nxt;

  logic w_tick;
  logic w_good;
  logic w_par_err;
  logic w_frm_err;

  logic [POS_W-1:0]  r_pos;
  logic              r_pos_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_link_up;
  logic [c_TO_W-1:0] r_to_cnt;

  bit_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk65MHz),
    .rst (rst),
    .i_d (link.rx_serial),
    .o_q (w_rx_s)
  );

  // State register for the frame decoder.
  always_ff @(posedge clk65MHz) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Baud/bit counters and data shift register.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Next-state logic: every bit is sampled when the baud counter hits zero,
  // which lands mid-bit because the start bit is timed with half a period.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_good      = 1'b0;
    w_par_err   = 1'b0;
    w_frm_err   = 1'b0;
    w_tick      = (r_baud == '0);

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_baud_nxt  = c_HALF_M1;
          w_bit_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (!w_tick) begin
          w_baud_nxt = r_baud - 1'b1;
        end else if (w_rx_s) begin
          // Line already back high: a glitch, not a start bit.
          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt  = c_FULL_M1;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (!w_tick) begin
          w_baud_nxt = r_baud - 1'b1;
        end else begin
          // LSB first: shift right so d[0] ends up in bit 0.
          w_shift_nxt = {w_rx_s, r_shift[POS_W-1:1]};
          w_baud_nxt  = c_FULL_M1;
          if (r_bit == c_LAST_BIT) w_state_nxt = PARITY;
          else                     w_bit_nxt   = r_bit + 1'b1;
        end
      end
      PARITY: begin
        if (!w_tick) begin
          w_baud_nxt = r_baud - 1'b1;
        end else begin
          w_par_nxt   = w_rx_s;
          w_baud_nxt  = c_FULL_M1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (!w_tick) begin
          w_baud_nxt = r_baud - 1'b1;
        end else if (!w_rx_s) begin
          // Bad stop bit wins; parity is meaningless on a broken frame.
          w_frm_err   = 1'b1;
          w_state_nxt = BREAK;
        end else if (even_parity(r_shift) != r_par) begin
          w_par_err   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          // Leave at mid-stop so a slightly fast peer's next start is caught.
          w_good      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      BREAK: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered outputs, link health timeout and held position.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      r_pos        <= c_RESET_POS;
      r_pos_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_link_up    <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_pos_valid  <= w_good;
      r_parity_err <= w_par_err;
      r_frame_err  <= w_frm_err;
      if (w_good) begin
        r_pos     <= r_shift;
        r_link_up <= 1'b1;
        r_to_cnt  <= '0;
      end else begin
        if (r_to_cnt != c_TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
        // Counter is about to reach the limit: peer is gone, centre paddle.
        if (r_link_up && (r_to_cnt == c_TO_LAST)) begin
          r_link_up <= 1'b0;
          r_pos     <= c_RESET_POS;
        end
      end
    end
  end

  assign link.pos        = r_pos;
  assign link.pos_valid  = r_pos_valid;
  assign link.parity_err = r_parity_err;
  assign link.frame_err  = r_frame_err;
  assign link.link_up    = r_link_up;

endmodule
`default_nettype wire

// File: tb/tb_pos_link_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_pos_link_rx                                              |
// | Brief  : Directed self-checking bench for pos_link_rx.              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_pos_link_rx;
  import pong_link_pkg::*;

  localparam int C_BIT = 8;
  localparam int C_TO  = 2000;
  localparam int C_RP  = 377;
  // Line change (1 ns after edge P0) -> 2 sync flops -> IDLE detect at P3,
  // then H=4 to mid-start and 12 more bit periods to mid-stop: 3+4+96.
  localparam int C_LAT = 3 + C_BIT / 2 + 12 * C_BIT;

  logic clk65MHz = 1'b0;
  logic rst;
  always #5 clk65MHz = ~clk65MHz;

  pos_link_rx_if u_if();

  pos_link_rx #(
    .CLKS_PER_BIT (C_BIT),
    .TIMEOUT_CLKS (C_TO),
    .RESET_POS    (C_RP)
  ) dut (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .link     (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk65MHz) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int          n_pv = 0, n_pe = 0, n_fe = 0;
  logic [9:0]  pv_q[$];
  int          last_pv_cyc = -1;
  int          fall_cyc = -1;
  logic [9:0]  fall_pos = '0;
  logic        fall_pv = 1'b0;
  logic        prev_link = 1'b0;
  always @(negedge clk65MHz) begin
    if (u_if.pos_valid === 1'b1) begin
      n_pv++;
      pv_q.push_back(u_if.pos);
      last_pv_cyc = cyc;
    end
    if (u_if.parity_err === 1'b1) n_pe++;
    if (u_if.frame_err === 1'b1) n_fe++;
    if (prev_link && (u_if.link_up === 1'b0)) begin
      fall_cyc = cyc;
      fall_pos = u_if.pos;
      fall_pv  = u_if.pos_valid;
    end
    prev_link = (u_if.link_up === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk65MHz);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] d, input logic par, input logic stp, output int c0);
    logic [12:0] bits;
    bits = {stp, par, d, 1'b0};
    c0 = cyc;
    for (int i = 0; i < 13; i++) begin
      u_if.rx_serial = bits[i];
      idle(C_BIT);
    end
  endtask

  task automatic send_good(input logic [9:0] d);
    int c0;
    send_frame(d, ^d, 1'b1, c0);
  endtask

  int c0, pv0, pe0, fe0, qn;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0d exp=%0d", cyc, 0);
    $fatal(1, "bench timed out");
  end

  initial begin
    u_if.rx_serial = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk65MHz);
    #1;
    rst = 1'b0;

    // 1. Reset state and a quiet idle line.
    check("rst_pos", u_if.pos, C_RP);
    check("rst_link", u_if.link_up, 0);
    idle(500);
    check("idle_pulses", n_pv + n_pe + n_fe, 0);
    check("idle_pos", u_if.pos, C_RP);

    // 2. Good frame 600 (even parity 0).
    pv0 = n_pv; pe0 = n_pe; fe0 = n_fe;
    send_frame(10'd600, 1'b0, 1'b1, c0);
    idle(4);
    check("f600_pv", n_pv - pv0, 1);
    check("f600_pos", u_if.pos, 600);
    check("f600_lat", last_pv_cyc - c0, C_LAT);
    check("f600_link", u_if.link_up, 1);
    check("f600_err", (n_pe - pe0) + (n_fe - fe0), 0);

    // 3. Value 5 has even parity 0; send 1 instead.
    pv0 = n_pv; pe0 = n_pe;
    send_frame(10'd5, 1'b1, 1'b1, c0);
    idle(4);
    check("par_pe", n_pe - pe0, 1);
    check("par_pv", n_pv - pv0, 0);
    check("par_pos", u_if.pos, 600);
    check("par_link", u_if.link_up, 1);

    // 4. Bad stop bit, line then held low for 300 more cycles.
    pv0 = n_pv; pe0 = n_pe; fe0 = n_fe;
    send_frame(10'd77, ^(10'd77), 1'b0, c0);
    idle(300);
    u_if.rx_serial = 1'b1;
    idle(20);
    check("brk_fe", n_fe - fe0, 1);
    check("brk_pv", n_pv - pv0, 0);
    check("brk_pe", n_pe - pe0, 0);
    check("brk_pos", u_if.pos, 600);
    pv0 = n_pv;
    send_good(10'd123);
    idle(4);
    check("f123_pv", n_pv - pv0, 1);
    check("f123_pos", u_if.pos, 123);

    // 5. Three-cycle low glitch, then three back-to-back frames.
    pv0 = n_pv; pe0 = n_pe; fe0 = n_fe;
    u_if.rx_serial = 1'b0;
    idle(3);
    u_if.rx_serial = 1'b1;
    idle(40);
    check("glitch_pulses", (n_pv - pv0) + (n_pe - pe0) + (n_fe - fe0), 0);
    pv0 = n_pv;
    qn  = pv_q.size();
    send_good(10'd1);
    send_good(10'd2);
    send_good(10'd1023);
    idle(4);
    check("b2b_pv", n_pv - pv0, 3);
    check("b2b_qlen", pv_q.size(), qn + 3);
    if (pv_q.size() >= qn + 3) begin
      check("b2b_0", pv_q[qn],     1);
      check("b2b_1", pv_q[qn + 1], 2);
      check("b2b_2", pv_q[qn + 2], 1023);
    end
    check("b2b_err", (n_pe - pe0) + (n_fe - fe0), 0);

    // 6a. Peer goes silent: link drops 2000 cycles after the last good frame.
    for (int i = 0; i < C_TO + 500 && fall_cyc < 0; i++) idle(1);
    check("to_seen", (fall_cyc >= 0), 1);
    check("to_delay", fall_cyc - last_pv_cyc, C_TO);
    check("to_pos", fall_pos, C_RP);
    check("to_no_pv", fall_pv, 0);
    check("to_link", u_if.link_up, 0);

    // 6b. Reset in the middle of the data bits of a frame.
    pv0 = n_pv; pe0 = n_pe; fe0 = n_fe;
    u_if.rx_serial = 1'b0;                 // start bit
    idle(C_BIT);
    for (int i = 0; i < 4; i++) begin      // first data bits of 10'h2AA
      u_if.rx_serial = i[0];
      idle(C_BIT);
    end
    rst = 1'b1;
    u_if.rx_serial = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(30);
    check("mrst_pulses", (n_pv - pv0) + (n_pe - pe0) + (n_fe - fe0), 0);
    check("mrst_pos", u_if.pos, C_RP);
    send_good(10'd42);
    idle(4);
    check("f42_pv", n_pv - pv0, 1);
    check("f42_pos", u_if.pos, 42);
    check("f42_err", (n_pe - pe0) + (n_fe - fe0), 0);
    check("f42_link", u_if.link_up, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
